k16_front_panel: RTL and testbench
==================================

# k16_front_panel

Memory-mapped front-panel responder for the K16 CPU. It owns the panel registers the CPU polls and writes: address switches, register-select switches and control command inputs on one side, address and data LEDs on the other. It sits on the CPU bus beside the synchronous RAM, answering reads with the same one-cycle latency. It debounces the physical panel buttons and turns them into the command code the CPU reads from the control register, plus a one-cycle `stop` pulse.

## Interface
- `BASE`, 16'hFFF0: base address of the 5-word register window.
- `DEBOUNCE_CYCLES`, 50000: clocks per debounce sample tick; legal range ≥ 2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `address` in 16: CPU bus address.
- `data_out` in 16: CPU write data.
- `write` in 1: CPU write strobe, sampled at posedge.
- `rd_data` out 16: read data for the address sampled at the previous posedge.
- `rd_hit` out 1: high when `rd_data` belongs to this block; the bus mux selects `rd_data` over RAM data when high.
- `sw_addr` in 16: raw address/data toggle switches (asynchronous).
- `sw_reg` in 4: raw register-select toggles (asynchronous).
- `btn` in 9: raw command buttons, active-high. Bit order [0..8]: START, INST_STEP, CONTINUE, EXAMINE, EXAMINE_NEXT, DEPOSIT, DEPOSIT_NEXT, EXAMINE_REGISTER, DEPOSIT_REGISTER.
- `btn_stop` in 1: raw STOP button, active-high.
- `stop` out 1: one-cycle pulse to CPU `stop`.
- `addr_leds` out 16: ADDR_LEDS register.
- `data_leds` out 16: DATA_LEDS register.

## Operation
- Register map, word offsets from `BASE`:
  - +0: ADDR_SWITCHES, read-only, synced `sw_addr`.
  - +1: CTRL_SWITCHES, read-only, current command code.
  - +2: ADDR_LEDS, read/write.
  - +3: DATA_LEDS, read/write.
  - +4: REG_SWITCHES, read-only, zero-extended synced `sw_reg`.
- Any address outside `BASE..BASE+4` is a miss: `rd_hit`=0 next cycle and `rd_data`=0.
- Writes to read-only offsets are ignored.
- All raw inputs pass through a 2-FF synchronizer.
- Debounce: a free-running tick counter fires every `DEBOUNCE_CYCLES` clocks. On each tick, the synced buttons are sampled. A button's debounced state takes the new sample only if it equals the previous tick's sample.
- CTRL_SWITCHES holds the K16 command define of the lowest-index debounced-pressed `btn` bit, and NONE when no button is pressed. It is level behaviour: the code stays while the button is held.
- `stop` pulses for one cycle on the debounced rising edge of `btn_stop`. Holding the button does not re-pulse.

## Timing
- Reset (`reset`=0, asynchronous): `rd_data`=0, `rd_hit`=0, `stop`=0, `addr_leds`=0, `data_leds`=0. Synchronizers, debounce state and tick counter are also 0.
- Read latency is 1 cycle: the address sampled at edge N produces `rd_data`/`rd_hit` valid after edge N, matching RAM.
- Write takes effect at the sampling edge: LED outputs change after that edge.
- A read of the same LED register at the same edge returns the old value. The new value is visible on the next access.
- Simultaneous `write` to a LED offset and read: the write wins the register, and `rd_data` shows the pre-write value.
- Switch latency: `sw_*` change reaches ADDR_SWITCHES/REG_SWITCHES readback in 2 cycles.
- Button latency (debounce on): between 1 and 2 ticks after synchronizer output. A glitch shorter than one tick period is never seen.
- Tick counter wraps `DEBOUNCE_CYCLES-1` → 0 without a gap.
- Multiple buttons pressed: the lowest index wins. If a lower button is released while a higher one is still held, the code switches to the next lowest at the next debounced update.
- Reset asserted mid-press: the command returns to NONE immediately. After release of reset the press must re-qualify through debounce; no `stop` pulse is generated by reset.

## Configuration
- `FRONT_PANEL_DEBOUNCE_EN`: when defined, the tick-based debounce is compiled in as described.
- When undefined: the tick counter and debounce registers are removed, debounced state equals synchronizer output, button latency is exactly 2 cycles, and `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset with `btn[0]`=1, then release reset. The bench must see:
  - all outputs 0 during reset;
  - CTRL read returns START within 2 ticks plus 2 cycles after release;
  - NONE within the same bound after `btn[0]` drops.
- `sw_addr`=16'h1234, `sw_reg`=3. The bench must see:
  - a read of `BASE+0` returns 16'h1234 with `rd_hit`=1, one cycle after the address;
  - a read of `BASE+4` returns 16'h0003;
  - a read of `BASE+5` gives `rd_hit`=0.
- Write 16'hABCD to `BASE+3`, then 16'h5678 to `BASE+2`. Required response:
  - `data_leds`=ABCD and `addr_leds`=5678 after each write edge;
  - readback matches;
  - writes to `BASE+1` leave CTRL unchanged.
- `btn[3]` and `btn[6]` pressed together, then `btn[3]` released. CTRL must read EXAMINE, then DEPOSIT_NEXT.
- Macro on: a 1-cycle `btn[1]` glitch gives CTRL that stays NONE. `btn_stop` held for 10 ticks gives exactly one 1-cycle `stop` pulse.
- Macro off: `btn_stop` rises and `stop` pulses exactly 3 cycles later, for 1 cycle.

Source files
------------

// File: rtl/k16_front_panel.sv
// rtl/k16_front_panel.sv - K16 front-panel register responder; optional debounce via FRONT_PANEL_DEBOUNCE_EN
module k16_front_panel #(
    parameter logic [15:0] BASE            = 16'hFFF0,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        write,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    input  logic [15:0] sw_addr,
    input  logic [3:0]  sw_reg,
    input  logic [8:0]  btn,
    input  logic        btn_stop,
    output logic        stop,
    output logic [15:0] addr_leds,
    output logic [15:0] data_leds
);

    // K16 command codes: NONE, then one code per button in btn bit order
    localparam logic [15:0] CMD_NONE = 16'd0;

    localparam logic [2:0] OFF_ADDR_SW  = 3'd0;
    localparam logic [2:0] OFF_CTRL_SW  = 3'd1;
    localparam logic [2:0] OFF_ADDR_LED = 3'd2;
    localparam logic [2:0] OFF_DATA_LED = 3'd3;
    localparam logic [2:0] OFF_REG_SW   = 3'd4;

    // raw panel inputs packed as {btn_stop, btn, sw_reg, sw_addr}
    logic [29:0] sync1_q, sync1_d;
    logic [29:0] sync2_q, sync2_d;

    logic [15:0] sync_sw_addr;
    logic [3:0]  sync_sw_reg;
    logic [9:0]  sync_btn;
    logic [9:0]  deb_btn;

    logic        stop_q, stop_d;
    logic        stop_prev_q, stop_prev_d;
    logic [15:0] addr_leds_q, addr_leds_d;
    logic [15:0] data_leds_q, data_leds_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_hit_q, rd_hit_d;

    logic [15:0] offset;
    logic        hit;
    logic [15:0] ctrl_code;

    // two-stage synchronizer next state for every asynchronous panel input
    always_comb begin
        sync1_d = {btn_stop, btn, sw_reg, sw_addr};
        sync2_d = sync1_q;
    end

    // two-stage synchronizer flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync_sw_addr = sync2_q[15:0];
    assign sync_sw_reg  = sync2_q[19:16];
    assign sync_btn     = sync2_q[29:20];

`ifdef FRONT_PANEL_DEBOUNCE_EN
    localparam int TICK_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_CYCLES - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [9:0]        sample_q, sample_d;
    logic [9:0]        deb_q, deb_d;
    logic              tick;
    logic [9:0]        agree;

    // free-running tick; a button bit only moves when two consecutive tick samples agree
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        agree      = ~(sync_btn ^ sample_q);
        sample_d   = sample_q;
        deb_d      = deb_q;
        if (tick) begin
            sample_d = sync_btn;
            deb_d    = (agree & sync_btn) | (~agree & deb_q);
        end
    end

    // debounce state flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            sample_q   <= '0;
            deb_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sample_q   <= sample_d;
            deb_q      <= deb_d;
        end
    end

    assign deb_btn = deb_q;
`else
    logic unused_debounce_cycles;

    assign deb_btn                = sync_btn;
    assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
`endif

    // lowest-index pressed button selects the command code
    always_comb begin
        ctrl_code = CMD_NONE;
        for (int i = 8; i >= 0; i--) begin
            if (deb_btn[i]) begin
                ctrl_code = 16'(i + 1);
            end
        end
    end

    // stop pulse on the debounced rising edge of the STOP button
    always_comb begin
        stop_prev_d = deb_btn[9];
        stop_d      = deb_btn[9] & ~stop_prev_q;
    end

    // register window decode, LED writes and one-cycle read path
    always_comb begin
        offset      = address - BASE;
        hit         = (offset < 16'd5);
        addr_leds_d = addr_leds_q;
        data_leds_d = data_leds_q;
        rd_hit_d    = hit;
        rd_data_d   = 16'd0;
        if (write && hit && offset[2:0] == OFF_ADDR_LED) begin
            addr_leds_d = data_out;
        end
        if (write && hit && offset[2:0] == OFF_DATA_LED) begin
            data_leds_d = data_out;
        end
        if (hit) begin
            case (offset[2:0])
                OFF_ADDR_SW:  rd_data_d = sync_sw_addr;
                OFF_CTRL_SW:  rd_data_d = ctrl_code;
                OFF_ADDR_LED: rd_data_d = addr_leds_q;
                OFF_DATA_LED: rd_data_d = data_leds_q;
                OFF_REG_SW:   rd_data_d = {12'd0, sync_sw_reg};
                default:      rd_data_d = 16'd0;
            endcase
        end
    end

    // bus-facing and stop flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stop_q      <= 1'b0;
            stop_prev_q <= 1'b0;
            addr_leds_q <= '0;
            data_leds_q <= '0;
            rd_data_q   <= '0;
            rd_hit_q    <= 1'b0;
        end else begin
            stop_q      <= stop_d;
            stop_prev_q <= stop_prev_d;
            addr_leds_q <= addr_leds_d;
            data_leds_q <= data_leds_d;
            rd_data_q   <= rd_data_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    assign stop      = stop_q;
    assign addr_leds = addr_leds_q;
    assign data_leds = data_leds_q;
    assign rd_data   = rd_data_q;
    assign rd_hit    = rd_hit_q;

endmodule

// File: tb/tb_k16_front_panel.sv
// tb/tb_k16_front_panel.sv - directed self-checking bench for k16_front_panel
module tb_k16_front_panel;

    localparam logic [15:0] BASE = 16'hFFF0;
    localparam int          DC   = 8;
`ifdef FRONT_PANEL_DEBOUNCE_EN
    localparam int CTRL_BUDGET = 2 * DC + 3;
`else
    localparam int CTRL_BUDGET = 3;
`endif

    localparam logic [15:0] CMD_NONE         = 16'd0;
    localparam logic [15:0] CMD_START        = 16'd1;
    localparam logic [15:0] CMD_EXAMINE      = 16'd4;
    localparam logic [15:0] CMD_DEPOSIT_NEXT = 16'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        write;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic [15:0] sw_addr;
    logic [3:0]  sw_reg;
    logic [8:0]  btn;
    logic        btn_stop;
    logic        stop;
    logic [15:0] addr_leds;
    logic [15:0] data_leds;

    int checks = 0;
    int errors = 0;
    int stop_cycles = 0;

    k16_front_panel #(
        .BASE            (BASE),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data_out  (data_out),
        .write     (write),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .sw_addr   (sw_addr),
        .sw_reg    (sw_reg),
        .btn       (btn),
        .btn_stop  (btn_stop),
        .stop      (stop),
        .addr_leds (addr_leds),
        .data_leds (data_leds)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stop === 1'b1) stop_cycles++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] a);
        address = a;
        write   = 1'b0;
        step();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address  = a;
        data_out = d;
        write    = 1'b1;
        step();
        write    = 1'b0;
    endtask

    task automatic wait_ctrl(input string tag, input logic [15:0] exp, input int budget);
        address = BASE + 16'd1;
        write   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (rd_hit === 1'b1 && rd_data === exp) break;
        end
        check_eq(tag, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        int          bad;
        logic [5:0]  pat;

        reset    = 1'b0;
        address  = 16'd0;
        data_out = 16'd0;
        write    = 1'b0;
        sw_addr  = 16'd0;
        sw_reg   = 4'd0;
        btn      = 9'b0_0000_0001;
        btn_stop = 1'b0;
        repeat (3) step();
        check_eq("rst_rd_data", rd_data, 16'd0);
        check_eq("rst_rd_hit", {15'd0, rd_hit}, 16'd0);
        check_eq("rst_stop", {15'd0, stop}, 16'd0);
        check_eq("rst_addr_leds", addr_leds, 16'd0);
        check_eq("rst_data_leds", data_leds, 16'd0);

        reset = 1'b1;
        wait_ctrl("ctrl_start_after_reset", CMD_START, CTRL_BUDGET);
        btn = 9'd0;
        wait_ctrl("ctrl_none_after_release", CMD_NONE, CTRL_BUDGET);

        sw_addr = 16'h1234;
        sw_reg  = 4'd3;
        repeat (3) step();
        bus_read(BASE);
        check_eq("rd_addr_sw", rd_data, 16'h1234);
        check_eq("rd_addr_sw_hit", {15'd0, rd_hit}, 16'd1);
        bus_read(BASE + 16'd4);
        check_eq("rd_reg_sw", rd_data, 16'h0003);
        bus_read(BASE + 16'd5);
        check_eq("miss_hi_hit", {15'd0, rd_hit}, 16'd0);
        check_eq("miss_hi_data", rd_data, 16'd0);
        bus_read(BASE - 16'd1);
        check_eq("miss_lo_hit", {15'd0, rd_hit}, 16'd0);

        bus_write(BASE + 16'd3, 16'hABCD);
        check_eq("wr_data_leds", data_leds, 16'hABCD);
        check_eq("wr_same_edge_old", rd_data, 16'h0000);
        bus_write(BASE + 16'd2, 16'h5678);
        check_eq("wr_addr_leds", addr_leds, 16'h5678);
        check_eq("wr_data_leds_kept", data_leds, 16'hABCD);
        bus_write(BASE + 16'd3, 16'h1111);
        check_eq("wr_same_edge_prev", rd_data, 16'hABCD);
        bus_write(BASE + 16'd3, 16'hABCD);
        bus_read(BASE + 16'd3);
        check_eq("rb_data_leds", rd_data, 16'hABCD);
        bus_read(BASE + 16'd2);
        check_eq("rb_addr_leds", rd_data, 16'h5678);
        bus_write(BASE + 16'd1, 16'hFFFF);
        bus_read(BASE + 16'd1);
        check_eq("ro_ctrl", rd_data, CMD_NONE);
        bus_write(BASE, 16'h0000);
        bus_read(BASE);
        check_eq("ro_addr_sw", rd_data, 16'h1234);
        bus_write(BASE + 16'd5, 16'h0F0F);
        check_eq("miss_wr_addr_leds", addr_leds, 16'h5678);
        check_eq("miss_wr_data_leds", data_leds, 16'hABCD);

        btn = 9'b0_0100_1000;
        wait_ctrl("ctrl_examine", CMD_EXAMINE, CTRL_BUDGET);
        btn = 9'b0_0100_0000;
        wait_ctrl("ctrl_deposit_next", CMD_DEPOSIT_NEXT, CTRL_BUDGET);
        btn = 9'd0;
        wait_ctrl("ctrl_none_multi", CMD_NONE, CTRL_BUDGET);

        btn = 9'd1;
        wait_ctrl("ctrl_start_again", CMD_START, CTRL_BUDGET + DC);
        s0 = stop_cycles;
        reset = 1'b0;
        #2;
        check_eq("midreset_rd_hit", {15'd0, rd_hit}, 16'd0);
        check_eq("midreset_addr_leds", addr_leds, 16'd0);
        repeat (2) step();
        reset = 1'b1;
        bus_read(BASE + 16'd1);
        check_eq("midreset_ctrl_none", rd_data, CMD_NONE);
        wait_ctrl("midreset_requalify", CMD_START, CTRL_BUDGET);
        btn = 9'd0;
        wait_ctrl("midreset_release", CMD_NONE, CTRL_BUDGET);
        check_eq("midreset_no_stop", 16'(stop_cycles - s0), 16'd0);

`ifdef FRONT_PANEL_DEBOUNCE_EN
        btn = 9'b0_0000_0010;
        step();
        btn = 9'd0;
        address = BASE + 16'd1;
        bad = 0;
        for (int i = 0; i < 3 * DC; i++) begin
            step();
            if (rd_data !== CMD_NONE) bad++;
        end
        check_eq("glitch_ignored", 16'(bad), 16'd0);

        s0 = stop_cycles;
        btn_stop = 1'b1;
        repeat (10 * DC) step();
        check_eq("stop_held_one_pulse", 16'(stop_cycles - s0), 16'd1);
        s0 = stop_cycles;
        btn_stop = 1'b0;
        repeat (3 * DC) step();
        check_eq("stop_release_no_pulse", 16'(stop_cycles - s0), 16'd0);
`else
        s0 = stop_cycles;
        btn_stop = 1'b1;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            pat[i] = stop;
        end
        check_eq("stop_timing", {10'd0, pat}, 16'h0004);
        repeat (10) step();
        check_eq("stop_held_one_pulse", 16'(stop_cycles - s0), 16'd1);
        s0 = stop_cycles;
        btn_stop = 1'b0;
        repeat (6) step();
        check_eq("stop_release_no_pulse", 16'(stop_cycles - s0), 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
